// File: rtl/hazard_scoreboard.sv
// Pipeline hazard/forwarding unit: decode stall, registered X-stage forward selects, mult/div tracker.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush performance counters.
module hazard_scoreboard #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned REG_W      = 5
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             dec_valid_i,
    input  logic [REG_W-1:0] dec_rs_i,
    input  logic [REG_W-1:0] dec_rb_i,
    input  logic             dec_use_a_i,
    input  logic             dec_use_b_i,
    input  logic             dec_rwe_i,
    input  logic [REG_W-1:0] dec_wreg_i,
    input  logic             dec_is_lw_i,
    input  logic             dec_is_md_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]      perf_stall_lu_o,
    output logic [31:0]      perf_stall_md_o,
    output logic [31:0]      perf_flush_o,
`endif
    output logic             md_busy_o,
    output logic             md_done_o,
    output logic [REG_W-1:0] md_wreg_o
);

    localparam logic [1:0] SelRf = 2'b00;
    localparam logic [1:0] SelM  = 2'b01;
    localparam logic [1:0] SelW  = 2'b10;
    localparam int unsigned CntW = 6;

    // The W stage is not tracked: the regfile is write-first, so nothing reads it.
    logic             x_valid_q, x_valid_d, x_rwe_q, x_rwe_d, x_is_lw_q, x_is_lw_d;
    logic             x_is_md_q, x_is_md_d;
    logic [REG_W-1:0] x_wreg_q, x_wreg_d;
    logic             m_valid_q, m_rwe_q, m_is_md_q;
    logic [REG_W-1:0] m_wreg_q;
    logic             md_busy_q, md_busy_d;
    logic [REG_W-1:0] md_wreg_q, md_wreg_d;
    logic [CntW-1:0]  md_cnt_q, md_cnt_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    logic             a_live, b_live, a_x, b_x, a_m, b_m;
    logic             lu_haz, md_pend, md_data_haz, md_struct_haz, stall_raw, issue;
    logic [REG_W-1:0] md_reg;

    function automatic logic [1:0] fwd_sel(input logic hit_x, input logic x_lw, input logic x_md,
                                           input logic hit_m, input logic m_md);
        if (hit_x && !x_lw && !x_md) return SelM;
        if (hit_m && !m_md)          return SelW;
        return SelRf;
    endfunction

    always_comb begin
        a_live = dec_use_a_i && (dec_rs_i != '0);
        b_live = dec_use_b_i && (dec_rb_i != '0);
        a_x    = a_live && x_valid_q && x_rwe_q && (x_wreg_q == dec_rs_i);
        b_x    = b_live && x_valid_q && x_rwe_q && (x_wreg_q == dec_rb_i);
        a_m    = a_live && m_valid_q && m_rwe_q && (m_wreg_q == dec_rs_i);
        b_m    = b_live && m_valid_q && m_rwe_q && (m_wreg_q == dec_rb_i);
        lu_haz = x_is_lw_q && (a_x || b_x);

        // A mult/div still sitting in X is as pending as one already counting down.
        md_pend       = md_busy_q || (x_valid_q && x_is_md_q);
        md_reg        = md_busy_q ? md_wreg_q : x_wreg_q;
        md_data_haz   = md_pend && ((a_live && (dec_rs_i == md_reg)) ||
                                    (b_live && (dec_rb_i == md_reg)) ||
                                    (dec_rwe_i && (dec_wreg_i != '0) && (dec_wreg_i == md_reg)));
        md_struct_haz = md_pend && dec_is_md_i;

        stall_raw = dec_valid_i && (lu_haz || md_data_haz || md_struct_haz);
        issue     = dec_valid_i && !stall_raw && !flush_i;

        x_valid_d = issue;
        x_rwe_d   = dec_rwe_i;
        x_wreg_d  = dec_wreg_i;
        x_is_lw_d = dec_is_lw_i;
        x_is_md_d = dec_is_md_i;
        fwd_a_d   = issue ? fwd_sel(a_x, x_is_lw_q, x_is_md_q, a_m, m_is_md_q) : SelRf;
        fwd_b_d   = issue ? fwd_sel(b_x, x_is_lw_q, x_is_md_q, b_m, m_is_md_q) : SelRf;
    end

    always_comb begin
        md_busy_d = md_busy_q;
        md_wreg_d = md_wreg_q;
        md_cnt_d  = md_cnt_q;
        if (md_busy_q) begin
            if (md_cnt_q == '0) md_busy_d = 1'b0;
            else                md_cnt_d  = md_cnt_q - CntW'(1);
        end
        if (x_valid_q && x_is_md_q) begin
            md_busy_d = 1'b1;
            md_wreg_d = x_wreg_q;
            md_cnt_d  = CntW'(MD_LATENCY - 1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            x_valid_q <= 1'b0;
            x_rwe_q   <= 1'b0;
            x_wreg_q  <= '0;
            x_is_lw_q <= 1'b0;
            x_is_md_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_rwe_q   <= 1'b0;
            m_wreg_q  <= '0;
            m_is_md_q <= 1'b0;
            md_busy_q <= 1'b0;
            md_wreg_q <= '0;
            md_cnt_q  <= '0;
            fwd_a_q   <= SelRf;
            fwd_b_q   <= SelRf;
        end else begin
            x_valid_q <= x_valid_d;
            x_rwe_q   <= x_rwe_d;
            x_wreg_q  <= x_wreg_d;
            x_is_lw_q <= x_is_lw_d;
            x_is_md_q <= x_is_md_d;
            m_valid_q <= x_valid_q;
            m_rwe_q   <= x_rwe_q;
            m_wreg_q  <= x_wreg_q;
            m_is_md_q <= x_is_md_q;
            md_busy_q <= md_busy_d;
            md_wreg_q <= md_wreg_d;
            md_cnt_q  <= md_cnt_d;
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
        end
    end

    assign stall_o     = stall_raw && !flush_i;
    assign fwd_a_sel_o = fwd_a_q;
    assign fwd_b_sel_o = fwd_b_q;
    assign md_busy_o   = md_busy_q;
    assign md_done_o   = md_busy_q && (md_cnt_q == '0) && !reset_i;
    assign md_wreg_o   = md_wreg_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_q, perf_md_q, perf_fl_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            perf_lu_q <= '0;
            perf_md_q <= '0;
            perf_fl_q <= '0;
        end else begin
            if (stall_o && lu_haz && (perf_lu_q != '1)) perf_lu_q <= perf_lu_q + 32'd1;
            if (stall_o && (md_data_haz || md_struct_haz) && (perf_md_q != '1)) begin
                perf_md_q <= perf_md_q + 32'd1;
            end
            if (flush_i && (perf_fl_q != '1)) perf_fl_q <= perf_fl_q + 32'd1;
        end
    end

    assign perf_stall_lu_o = perf_lu_q;
    assign perf_stall_md_o = perf_md_q;
    assign perf_flush_o    = perf_fl_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: issue-history model checked every cycle plus directed literal checks.
module tb_hazard_scoreboard;

    localparam int Lat   = 4;
    localparam int Depth = 1024;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rb;
        logic       ua;
        logic       ub;
        logic       rwe;
        logic [4:0] wreg;
        logic       lw;
        logic       md;
    } instr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv = 1'b0, ua = 1'b0, ub = 1'b0, rwe = 1'b0, lw = 1'b0, md = 1'b0, fl = 1'b0;
    logic [4:0] rs = '0, rb = '0, wreg = '0;
    logic       stall, busy, done;
    logic [1:0] fa, fb;
    logic [4:0] mdw;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .MD_LATENCY(Lat),
        .REG_W     (5)
    ) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .dec_valid_i(dv),
        .dec_rs_i   (rs),
        .dec_rb_i   (rb),
        .dec_use_a_i(ua),
        .dec_use_b_i(ub),
        .dec_rwe_i  (rwe),
        .dec_wreg_i (wreg),
        .dec_is_lw_i(lw),
        .dec_is_md_i(md),
        .flush_i    (fl),
        .stall_o    (stall),
        .fwd_a_sel_o(fa),
        .fwd_b_sel_o(fb),
        .md_busy_o  (busy),
        .md_done_o  (done),
        .md_wreg_o  (mdw)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: what was accepted from decode in each cycle, and when the last mult/div issued.
    logic       iss_v   [Depth];
    logic       iss_rwe [Depth];
    logic       iss_lw  [Depth];
    logic       iss_md  [Depth];
    logic [4:0] iss_wreg[Depth];
    int         md_c = -1000;
    logic       e_stall, e_issue, e_busy, e_done;
    logic [1:0] e_fa = 2'b00, e_fb = 2'b00, e_fa_next, e_fb_next;

    function automatic logic wrote(input int k, input logic use_it, input logic [4:0] src);
        if (k < 0) return 1'b0;
        return iss_v[k] && iss_rwe[k] && (iss_wreg[k] == src) && (src != 5'd0) && use_it;
    endfunction

    function automatic logic [1:0] sel(input int now, input logic use_it, input logic [4:0] src);
        if (wrote(now - 1, use_it, src) && !iss_lw[now - 1] && !iss_md[now - 1]) return 2'b01;
        if (wrote(now - 2, use_it, src) && !iss_md[now - 2]) return 2'b10;
        return 2'b00;
    endfunction

    always @(negedge clk) begin : compare
        logic       lu, haz, pend, st;
        logic [4:0] mreg;
        int         now;
        now    = cyc;
        lu     = (wrote(now - 1, ua, rs) || wrote(now - 1, ub, rb)) && iss_lw[now - 1];
        pend   = (md_c >= 0) && (now >= md_c + 1) && (now <= md_c + 1 + Lat);
        e_busy = (md_c >= 0) && (now >= md_c + 2) && (now <= md_c + 1 + Lat);
        e_done = (md_c >= 0) && (now == md_c + 1 + Lat);
        mreg   = pend ? iss_wreg[md_c] : 5'd0;
        haz    = pend && ((ua && rs != 0 && rs == mreg) || (ub && rb != 0 && rb == mreg) ||
                          (rwe && wreg != 0 && wreg == mreg));
        st     = pend && md;
        e_stall   = dv && !fl && (lu || haz || st);
        e_issue   = dv && !fl && !(lu || haz || st);
        e_fa_next = e_issue ? sel(now, ua, rs) : 2'b00;
        e_fb_next = e_issue ? sel(now, ub, rb) : 2'b00;
        if (rst) begin
            check("md_done_in_reset", done, 0);
        end else begin
            check("model_stall", stall, e_stall);
            check("model_md_busy", busy, e_busy);
            check("model_md_done", done, e_done);
            check("model_fwd_a", fa, e_fa);
            check("model_fwd_b", fb, e_fb);
            if (e_busy) check("model_md_wreg", mdw, iss_wreg[md_c]);
        end
    end

    always @(posedge clk) begin : model
        if (cyc >= Depth - 1) begin
            $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cyc, Depth - 1);
            $fatal(1);
        end
        if (rst) begin
            iss_v[cyc] = 1'b0;
            if (cyc > 0) iss_v[cyc - 1] = 1'b0;
            md_c = -1000;
            e_fa = 2'b00;
            e_fb = 2'b00;
        end else begin
            iss_v[cyc]    = e_issue;
            iss_rwe[cyc]  = rwe;
            iss_lw[cyc]   = lw;
            iss_md[cyc]   = md;
            iss_wreg[cyc] = wreg;
            if (e_issue && md) md_c = cyc;
            e_fa = e_fa_next;
            e_fb = e_fb_next;
        end
        cyc++;
    end

    function automatic instr_t alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rs = s; i.rb = t; i.ua = 1'b1; i.ub = 1'b1; i.rwe = 1'b1; i.wreg = d;
        return i;
    endfunction

    function automatic instr_t ldw(input logic [4:0] d, input logic [4:0] base);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rs = base; i.rb = d; i.ua = 1'b1; i.rwe = 1'b1; i.wreg = d; i.lw = 1'b1;
        return i;
    endfunction

    function automatic instr_t mdv(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        instr_t i;
        i = alu(d, s, t);
        i.md = 1'b1;
        return i;
    endfunction

    // Drive one decode cycle, then return in the sampling window of that same cycle.
    task automatic tick(input instr_t i, input logic f, input logic r);
        @(posedge clk);
        #1;
        dv = i.v; rs = i.rs; rb = i.rb; ua = i.ua; ub = i.ub; rwe = i.rwe;
        wreg = i.wreg; lw = i.lw; md = i.md; fl = f; rst = r;
        @(negedge clk);
        #1;
    endtask

    instr_t nop;

    initial begin
        nop = '0;
        tick(nop, 1'b0, 1'b1);
        tick(nop, 1'b0, 1'b1);
        tick(nop, 1'b0, 1'b0);
        check("rst_stall", stall, 0);
        check("rst_md_busy", busy, 0);
        check("rst_md_done", done, 0);
        check("rst_fwd_a", fa, 0);
        check("rst_fwd_b", fb, 0);
        check("rst_md_wreg", mdw, 0);

        // lw r5 ; add r6,r5,r7 -> one stall, then W forward
        tick(ldw(5'd5, 5'd1), 1'b0, 1'b0);
        check("t1_lw_nostall", stall, 0);
        tick(alu(5'd6, 5'd5, 5'd7), 1'b0, 1'b0);
        check("t1_loaduse_stall", stall, 1);
        tick(alu(5'd6, 5'd5, 5'd7), 1'b0, 1'b0);
        check("t1_release", stall, 0);
        check("t1_bubble_sel", fa, 2'b00);
        tick(nop, 1'b0, 1'b0);
        check("t1_fwd_a_w", fa, 2'b10);
        check("t1_fwd_b_rf", fb, 2'b00);

        // add r3 ; sub r4,r3,r3 -> both from M
        tick(alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b0);
        tick(alu(5'd4, 5'd3, 5'd3), 1'b0, 1'b0);
        check("t2_nostall", stall, 0);
        tick(nop, 1'b0, 1'b0);
        check("t2_fwd_a_m", fa, 2'b01);
        check("t2_fwd_b_m", fb, 2'b01);

        // add r3 ; nop ; add r8,r3,r0
        tick(alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b0);
        tick(nop, 1'b0, 1'b0);
        tick(alu(5'd8, 5'd3, 5'd0), 1'b0, 1'b0);
        tick(nop, 1'b0, 1'b0);
        check("t3_fwd_a_w", fa, 2'b10);
        check("t3_fwd_b_r0", fb, 2'b00);

        // writer of r0 never forwards
        tick(alu(5'd0, 5'd1, 5'd2), 1'b0, 1'b0);
        tick(alu(5'd20, 5'd0, 5'd0), 1'b0, 1'b0);
        check("t3_r0_nostall", stall, 0);
        tick(nop, 1'b0, 1'b0);
        check("t3_r0_fwd_a", fa, 2'b00);
        check("t3_r0_fwd_b", fb, 2'b00);

        // mul r9 ; add r10,r9,r1 -> stall through md_done
        tick(mdv(5'd9, 5'd1, 5'd2), 1'b0, 1'b0);
        check("t4_mul_issue", stall, 0);
        tick(alu(5'd10, 5'd9, 5'd1), 1'b0, 1'b0);
        check("t4_stall_mul_in_x", stall, 1);
        check("t4_not_busy_yet", busy, 0);
        for (int k = 1; k <= Lat; k++) begin
            tick(alu(5'd10, 5'd9, 5'd1), 1'b0, 1'b0);
            check("t4_busy", busy, 1);
            check("t4_stall", stall, 1);
            check("t4_done", done, (k == Lat) ? 1 : 0);
            check("t4_md_wreg", mdw, 9);
        end
        tick(alu(5'd10, 5'd9, 5'd1), 1'b0, 1'b0);
        check("t4_issue", stall, 0);
        check("t4_idle", busy, 0);
        check("t4_done_once", done, 0);
        tick(nop, 1'b0, 1'b0);
        check("t4_fwd_a", fa, 2'b00);
        check("t4_fwd_b", fb, 2'b00);

        // mul r9 ; add r12 (unrelated) ; div r11 -> structural stall
        tick(mdv(5'd9, 5'd1, 5'd2), 1'b0, 1'b0);
        tick(alu(5'd12, 5'd1, 5'd2), 1'b0, 1'b0);
        check("t5_unrelated", stall, 0);
        for (int k = 1; k <= Lat; k++) begin
            tick(mdv(5'd11, 5'd3, 5'd4), 1'b0, 1'b0);
            check("t5_struct_stall", stall, 1);
            check("t5_done", done, (k == Lat) ? 1 : 0);
        end
        tick(mdv(5'd11, 5'd3, 5'd4), 1'b0, 1'b0);
        check("t5_div_issue", stall, 0);
        tick(nop, 1'b0, 1'b0);
        check("t5_div_in_x", busy, 0);
        tick(nop, 1'b0, 1'b0);
        check("t5_div_busy", busy, 1);
        check("t5_div_wreg", mdw, 11);
        repeat (Lat + 1) tick(nop, 1'b0, 1'b0);

        // flush coincident with load-use stall
        tick(ldw(5'd5, 5'd1), 1'b0, 1'b0);
        tick(alu(5'd6, 5'd5, 5'd7), 1'b1, 1'b0);
        check("t6_flush_overrides", stall, 0);
        tick(alu(5'd13, 5'd6, 5'd6), 1'b0, 1'b0);
        check("t6_after_flush", stall, 0);
        tick(nop, 1'b0, 1'b0);
        check("t6_dropped_a", fa, 2'b00);
        check("t6_dropped_b", fb, 2'b00);

        // reset landing on the md_done cycle
        tick(mdv(5'd9, 5'd1, 5'd2), 1'b0, 1'b0);
        tick(nop, 1'b0, 1'b0);
        for (int k = 1; k < Lat; k++) tick(nop, 1'b0, 1'b0);
        check("t6_mid_mul_busy", busy, 1);
        tick(nop, 1'b0, 1'b1);
        check("t6_reset_no_done", done, 0);
        tick(nop, 1'b0, 1'b0);
        check("t6_reset_busy", busy, 0);
        check("t6_reset_done", done, 0);
        check("t6_reset_wreg", mdw, 0);
        repeat (2) tick(nop, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
